// File: rtl/iq_free_list.sv
// Free list of issue queue entry IDs held in a circular buffer.
// It offers up to DISPATCH_WIDTH IDs per cycle and takes back up to ISSUE_WIDTH granted IDs per cycle.
module iq_free_list #(
    parameter int IQ_SIZE        = 32,
    parameter int IQ_SIZE_LOG    = 5,
    parameter int DISPATCH_WIDTH = 4,
    parameter int ISSUE_WIDTH    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush_i,
    input  logic                                  dispatchReady_i,
    input  logic [DISPATCH_WIDTH-1:0]             dispatchLaneActive_i,
    input  logic [ISSUE_WIDTH-1:0]                grantValid_i,
    input  logic [ISSUE_WIDTH*IQ_SIZE_LOG-1:0]    grantId_i,
    output logic [DISPATCH_WIDTH*IQ_SIZE_LOG-1:0] freeEntryId_o,
    output logic [DISPATCH_WIDTH-1:0]             freeEntryValid_o,
    output logic                                  stall_o,
    output logic [IQ_SIZE_LOG:0]                  freeCnt_o,
    output logic                                  error_o
);
    localparam int CW = IQ_SIZE_LOG + 1;

    logic [IQ_SIZE_LOG-1:0] fifo_q [IQ_SIZE];
    logic [IQ_SIZE_LOG-1:0] fifo_d [IQ_SIZE];
    logic [IQ_SIZE_LOG-1:0] head_q, head_d;
    logic [IQ_SIZE_LOG-1:0] tail_q, tail_d;
    logic [CW-1:0]          free_cnt_q, free_cnt_d;
    logic                   error_q, error_d;

    logic [CW-1:0]          n_act;
    logic [CW-1:0]          pops;
    logic [CW-1:0]          pushes;
    logic [CW:0]            cnt_sum;
    logic [IQ_SIZE_LOG-1:0] wr_idx;
    logic [CW-1:0]          rank;
    logic                   stall;

    // Active lanes are compacted: each one takes the next ID after those taken by lower active lanes.
    always_comb begin
        rank             = '0;
        freeEntryId_o    = '0;
        freeEntryValid_o = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            freeEntryId_o[k*IQ_SIZE_LOG +: IQ_SIZE_LOG] = fifo_q[head_q + rank[IQ_SIZE_LOG-1:0]];
            freeEntryValid_o[k] = dispatchLaneActive_i[k] && (rank < free_cnt_q);
            if (dispatchLaneActive_i[k]) begin
                rank = rank + CW'(1);
            end
        end
        n_act = rank;
    end

    assign stall   = (free_cnt_q < n_act);
    assign pops    = (dispatchReady_i && !stall) ? n_act : '0;
    assign stall_o = stall;

    always_comb begin
        fifo_d = fifo_q;
        wr_idx = tail_q;
        pushes = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (grantValid_i[k]) begin
                fifo_d[wr_idx] = grantId_i[k*IQ_SIZE_LOG +: IQ_SIZE_LOG];
                wr_idx         = wr_idx + IQ_SIZE_LOG'(1);
                pushes         = pushes + CW'(1);
            end
        end

        // pops never exceed free_cnt_q, so the difference cannot underflow
        cnt_sum    = {1'b0, free_cnt_q} - {1'b0, pops} + {1'b0, pushes};
        head_d     = head_q + pops[IQ_SIZE_LOG-1:0];
        tail_d     = wr_idx;
        free_cnt_d = cnt_sum[CW-1:0];
        error_d    = error_q;
        if (cnt_sum > (CW+1)'(IQ_SIZE)) begin
            free_cnt_d = CW'(IQ_SIZE);
            error_d    = 1'b1;
        end

        // A flush discards this cycle's traffic but keeps a previously recorded error
        if (flush_i) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                fifo_d[i] = IQ_SIZE_LOG'(i);
            end
            head_d     = '0;
            tail_d     = '0;
            free_cnt_d = CW'(IQ_SIZE);
            error_d    = error_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                fifo_q[i] <= IQ_SIZE_LOG'(i);
            end
            head_q     <= '0;
            tail_q     <= '0;
            free_cnt_q <= CW'(IQ_SIZE);
            error_q    <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            free_cnt_q <= free_cnt_d;
            error_q    <= error_d;
        end
    end

    assign freeCnt_o = free_cnt_q;
    assign error_o   = error_q;

endmodule

// File: tb/tb_iq_free_list.sv
// Scoreboard bench for iq_free_list: a queue-based free-list model predicts each cycle's outputs,
// and a negedge monitor compares them against the DUT.
module tb_iq_free_list;
    localparam int N  = 32;
    localparam int LG = 5;
    localparam int DW = 4;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_i;
    logic             dispatchReady_i;
    logic [DW-1:0]    dispatchLaneActive_i;
    logic [IW-1:0]    grantValid_i;
    logic [IW*LG-1:0] grantId_i;
    logic [DW*LG-1:0] freeEntryId_o;
    logic [DW-1:0]    freeEntryValid_o;
    logic             stall_o;
    logic [LG:0]      freeCnt_o;
    logic             error_o;

    iq_free_list #(.IQ_SIZE(N), .IQ_SIZE_LOG(LG), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .dispatchReady_i(dispatchReady_i),
        .dispatchLaneActive_i(dispatchLaneActive_i), .grantValid_i(grantValid_i),
        .grantId_i(grantId_i), .freeEntryId_o(freeEntryId_o), .freeEntryValid_o(freeEntryValid_o),
        .stall_o(stall_o), .freeCnt_o(freeCnt_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             stall;
        int               cnt;
        logic             err;
        logic [DW-1:0]    vld;
        logic [DW*LG-1:0] ids;
        logic [DW*LG-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: ordered list of free IDs, IDs currently handed out, count and error flag
    int   fl[$];
    int   inuse[$];
    int   m_cnt;
    bit   m_err;
    bit   m_exact;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW*LG-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [DW*LG-1:0] v;
        v = {LG'(d), LG'(c), LG'(b), LG'(a)};
        return v;
    endfunction

    task automatic model_restore();
        fl.delete();
        inuse.delete();
        for (int i = 0; i < N; i++) fl.push_back(i);
        m_cnt   = N;
        m_exact = 1'b1;
    endtask

    task automatic cycle(input logic [DW-1:0] act, input logic rdy, input logic [IW-1:0] gv,
                         input logic [IW*LG-1:0] gid, input logic fls);
        exp_t e;
        int   nact;
        int   r;
        int   pops;
        int   pushes;
        int   nc;
        @(posedge clk);
        #1;
        dispatchLaneActive_i = act;
        dispatchReady_i      = rdy;
        grantValid_i         = gv;
        grantId_i            = gid;
        flush_i              = fls;

        nact    = $countones(act);
        e.stall = (m_cnt < nact);
        e.cnt   = m_cnt;
        e.err   = m_err;
        e.vld   = '0;
        e.ids   = '0;
        e.mask  = '0;
        r       = 0;
        for (int k = 0; k < DW; k++) begin
            if (act[k]) begin
                if (r < m_cnt) begin
                    e.vld[k] = 1'b1;
                    if (m_exact) begin
                        e.ids[k*LG +: LG]  = LG'(fl[r]);
                        e.mask[k*LG +: LG] = '1;
                    end
                end
                r++;
            end
        end
        sb.push_back(e);

        if (fls) begin
            model_restore();
        end else begin
            pops   = (rdy && !e.stall) ? nact : 0;
            pushes = 0;
            for (int i = 0; i < pops; i++) begin
                if (fl.size() > 0) inuse.push_back(fl.pop_front());
            end
            for (int k = 0; k < IW; k++) begin
                if (gv[k]) begin
                    fl.push_back(int'(gid[k*LG +: LG]));
                    pushes++;
                end
            end
            nc = m_cnt - pops + pushes;
            if (nc > N) begin
                m_err   = 1'b1;
                m_exact = 1'b0;
                nc      = N;
            end
            m_cnt = nc;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall", 32'(stall_o), 32'(e.stall));
            chk("free_cnt", 32'(freeCnt_o), e.cnt);
            chk("error", 32'(error_o), 32'(e.err));
            chk("valid", 32'(freeEntryValid_o), 32'(e.vld));
            chk("ids", 32'(freeEntryId_o & e.mask), 32'(e.ids));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [IW-1:0]    gv;
        logic [IW*LG-1:0] gid;
        int               idx;

        reset                = 1'b1;
        flush_i              = 1'b0;
        dispatchReady_i      = 1'b0;
        dispatchLaneActive_i = 4'hF;
        grantValid_i         = '0;
        grantId_i            = '0;
        model_restore();
        m_err = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_cnt", 32'(freeCnt_o), 32);
        chk("rst_err", 32'(error_o), 0);
        chk("rst_ids", 32'(freeEntryId_o), 32'(pack4(0, 1, 2, 3)));
        dispatchLaneActive_i = 4'h0;
        #1;
        chk("rst_stall", 32'(stall_o), 0);
        #1;
        reset = 1'b0;

        // full bundle dispatch
        cycle(4'hF, 1'b1, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("first_ids", 32'(freeEntryId_o), 32'(pack4(0, 1, 2, 3)));
        cycle(4'hF, 1'b0, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("second_cnt", 32'(freeCnt_o), 28);
        chk("second_ids", 32'(freeEntryId_o), 32'(pack4(4, 5, 6, 7)));

        // sparse lanes 1 and 3
        cycle(4'b1010, 1'b1, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("sparse_valid", 32'(freeEntryValid_o), 32'b1010);
        chk("sparse_l1", 32'(freeEntryId_o[1*LG +: LG]), 4);
        chk("sparse_l3", 32'(freeEntryId_o[3*LG +: LG]), 5);

        // drain to 2 free, then stall while two IDs come back
        repeat (6) cycle(4'hF, 1'b1, 4'h0, '0, 1'b0);
        cycle(4'hF, 1'b1, 4'b0011, pack4(9, 14, 0, 0), 1'b0);
        @(negedge clk);
        chk("drain_stall", 32'(stall_o), 1);
        chk("drain_cnt", 32'(freeCnt_o), 2);
        cycle(4'hF, 1'b0, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("refill_cnt", 32'(freeCnt_o), 4);
        chk("refill_stall", 32'(stall_o), 0);
        chk("refill_ids", 32'(freeEntryId_o), 32'(pack4(30, 31, 9, 14)));

        // flush at 5 free with concurrent grant and dispatch
        cycle(4'h0, 1'b0, 4'b0001, pack4(3, 0, 0, 0), 1'b0);
        cycle(4'hF, 1'b1, 4'b0001, pack4(0, 0, 0, 0), 1'b1);
        cycle(4'hF, 1'b0, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("flush_cnt", 32'(freeCnt_o), 32);
        chk("flush_ids", 32'(freeEntryId_o), 32'(pack4(0, 1, 2, 3)));

        // pop 30 then push 4 so the offered window straddles index 31 -> 0
        repeat (7) cycle(4'hF, 1'b1, 4'h0, '0, 1'b0);
        cycle(4'b0011, 1'b1, 4'h0, '0, 1'b0);
        cycle(4'hF, 1'b0, 4'hF, pack4(10, 20, 5, 7), 1'b0);
        cycle(4'hF, 1'b0, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("wrap_ids", 32'(freeEntryId_o), 32'(pack4(30, 31, 10, 20)));
        chk("wrap_cnt", 32'(freeCnt_o), 6);

        // overflow when full; sticky across flush, cleared by reset
        cycle(4'h0, 1'b0, 4'h0, '0, 1'b1);
        cycle(4'h0, 1'b0, 4'b0001, pack4(5, 0, 0, 0), 1'b0);
        cycle(4'h0, 1'b0, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("ovf_err", 32'(error_o), 1);
        chk("ovf_cnt", 32'(freeCnt_o), 32);
        cycle(4'h0, 1'b0, 4'h0, '0, 1'b1);
        cycle(4'h0, 1'b0, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("ovf_err_flush", 32'(error_o), 1);
        #2;
        reset = 1'b1;
        model_restore();
        m_err = 1'b0;
        @(negedge clk);
        chk("ovf_err_reset", 32'(error_o), 0);
        #2;
        reset = 1'b0;

        // randomized traffic: grants only return IDs that were handed out
        for (int c = 0; c < 3000; c++) begin
            gv  = '0;
            gid = '0;
            for (int k = 0; k < IW; k++) begin
                if ($urandom_range(0, 2) == 0 && inuse.size() > 0) begin
                    idx = $urandom_range(0, inuse.size() - 1);
                    gv[k] = 1'b1;
                    gid[k*LG +: LG] = LG'(inuse[idx]);
                    inuse.delete(idx);
                end
            end
            cycle(DW'($urandom), ($urandom_range(0, 9) < 8), gv, gid, ($urandom_range(0, 49) == 0));
        end
        cycle(4'h0, 1'b0, 4'h0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
